// File: rtl/score_to_segments.sv
// score_to_segments: sequential double-dabble conversion of a binary score into
// four active-low 7-segment patterns {dp,g,f,e,d,c,b,a} (thousands..ones).
// The outputs hold the previous result until a conversion completes.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module score_to_segments #(
  parameter int unsigned SCORE_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               valid,
  output logic               sat,
  output logic [7:0]         thousands,
  output logic [7:0]         hundreds,
  output logic [7:0]         tens,
  output logic [7:0]         ones
);

  localparam int unsigned CNT_W  = $clog2(SCORE_W + 1);
  localparam int unsigned EXT_W  = 14;
  localparam logic [EXT_W-1:0] MAX_SCORE = EXT_W'(9999);
  localparam logic [7:0] SEG_ZERO  = 8'hC0;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] RST_UPPER = SEG_BLANK;
`else
  localparam logic [7:0] RST_UPPER = SEG_ZERO;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ENCODE = 2'd2
  } state_e;

  state_e             state_q;
  logic [SCORE_W-1:0] bin_q;
  logic [15:0]        bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               clamp_q;
  logic               busy_q;
  logic               valid_q;
  logic               sat_q;
  logic [7:0]         thousands_q;
  logic [7:0]         hundreds_q;
  logic [7:0]         tens_q;
  logic [7:0]         ones_q;

  logic [EXT_W-1:0]   score_ext;
  logic               clamp_d;
  logic [SCORE_W-1:0] bin_load_d;
  logic [15:0]        bcd_adj;
  logic [15:0]        bcd_shift_d;
  logic [7:0]         seg_th_d;
  logic [7:0]         seg_hu_d;
  logic [7:0]         seg_te_d;
  logic [7:0]         seg_on_d;

  // Active-low 7-segment encoding of one BCD nibble; non-BCD codes are blank.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Input clamp, add-3 correction with shift, and digit encoding.
  always_comb begin
    score_ext  = EXT_W'(score);
    clamp_d    = (score_ext > MAX_SCORE);
    bin_load_d = clamp_d ? SCORE_W'(MAX_SCORE) : score;

    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_shift_d = (bcd_adj << 1) | 16'(bin_q[SCORE_W-1]);

    seg_th_d = seg7(bcd_q[15:12]);
    seg_hu_d = seg7(bcd_q[11:8]);
    seg_te_d = seg7(bcd_q[7:4]);
    seg_on_d = seg7(bcd_q[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (bcd_q[15:12] == 4'd0) begin
      seg_th_d = SEG_BLANK;
      if (bcd_q[11:8] == 4'd0) begin
        seg_hu_d = SEG_BLANK;
        if (bcd_q[7:4] == 4'd0) seg_te_d = SEG_BLANK;
      end
    end
`endif
  end

  // Conversion FSM with registered handshake and digit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      clamp_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      thousands_q <= RST_UPPER;
      hundreds_q  <= RST_UPPER;
      tens_q      <= RST_UPPER;
      ones_q      <= SEG_ZERO;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= bin_load_d;
            clamp_q <= clamp_d;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_shift_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SCORE_W - 1)) state_q <= ENCODE;
        end
        ENCODE: begin
          thousands_q <= seg_th_d;
          hundreds_q  <= seg_hu_d;
          tens_q      <= seg_te_d;
          ones_q      <= seg_on_d;
          sat_q       <= clamp_q;
          valid_q     <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign sat       = sat_q;
  assign thousands = thousands_q;
  assign hundreds  = hundreds_q;
  assign tens      = tens_q;
  assign ones      = ones_q;

endmodule

// File: tb/tb_score_to_segments.sv
// Directed testbench for score_to_segments (SCORE_W = 14).
module tb_score_to_segments;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] score;
  logic        busy;
  logic        valid;
  logic        sat;
  logic [7:0]  thousands;
  logic [7:0]  hundreds;
  logic [7:0]  tens;
  logic [7:0]  ones;

  int vectors;
  int errors;
  int lat;
  int vcount;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  score_to_segments #(.SCORE_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .score     (score),
    .busy      (busy),
    .valid     (valid),
    .sat       (sat),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_digits(input string tag, input logic [7:0] th, input logic [7:0] hu,
                            input logic [7:0] te, input logic [7:0] on);
    chk({tag, ".thousands"}, 32'(thousands), 32'(th));
    chk({tag, ".hundreds"},  32'(hundreds),  32'(hu));
    chk({tag, ".tens"},      32'(tens),      32'(te));
    chk({tag, ".ones"},      32'(ones),      32'(on));
  endtask

  // Pulse start with score s; returns edges from acceptance to the valid cycle.
  task automatic run(input logic [13:0] s, output int l);
    score = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    l = 0;
    while (valid !== 1'b1 && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    score   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy",  32'(busy),  32'd0);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.sat",   32'(sat),   32'd0);
    chk_digits("rst", LZ, LZ, LZ, 8'hC0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1234
    run(14'd1234, lat);
    chk("1234.latency", 32'(lat), 32'd15);
    chk("1234.busy",    32'(busy), 32'd0);
    chk("1234.sat",     32'(sat),  32'd0);
    chk_digits("1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
    @(posedge clk); #1;
    chk("1234.valid_one_cycle", 32'(valid), 32'd0);

    // 0
    run(14'd0, lat);
    chk("0.latency", 32'(lat), 32'd15);
    chk_digits("0", LZ, LZ, LZ, 8'hC0);

    // 10000 clamps
    run(14'd10000, lat);
    chk("10000.sat", 32'(sat), 32'd1);
    chk_digits("10000", 8'h90, 8'h90, 8'h90, 8'h90);

    // 16383 clamps, started back-to-back in the IDLE cycle after valid
    run(14'd16383, lat);
    chk("16383.latency", 32'(lat), 32'd15);
    chk("16383.sat", 32'(sat), 32'd1);
    chk_digits("16383", 8'h90, 8'h90, 8'h90, 8'h90);

    // 9999 does not clamp
    run(14'd9999, lat);
    chk("9999.sat", 32'(sat), 32'd0);
    chk_digits("9999", 8'h90, 8'h90, 8'h90, 8'h90);
    @(posedge clk); #1;

    // 42 with score change and start re-asserted mid-conversion
    score = 14'd42;
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    vcount = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) begin
        score = 14'd7;
        start = 1'b1;
      end
      if (c == 7) start = 1'b0;
      if (c == 8) begin
        chk("42.hold_busy", 32'(busy), 32'd1);
        chk_digits("42.hold", 8'h90, 8'h90, 8'h90, 8'h90);
      end
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        vcount++;
        if (vcount == 1) begin
          chk("42.latency", 32'(c), 32'd15);
          chk_digits("42", LZ, LZ, 8'h99, 8'hA4);
        end
      end
    end
    chk("42.valid_count", 32'(vcount), 32'd1);

    // Reset at SHIFT iteration 6
    score = 14'd1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.busy",  32'(busy),  32'd0);
    chk("midrst.valid", 32'(valid), 32'd0);
    chk("midrst.sat",   32'(sat),   32'd0);
    chk_digits("midrst", LZ, LZ, LZ, 8'hC0);
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) vcount++;
    end
    chk("midrst.no_valid", 32'(vcount), 32'd0);

    // 5 after reset
    run(14'd5, lat);
    chk("5.latency", 32'(lat), 32'd15);
    chk_digits("5", LZ, LZ, LZ, 8'h92);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/score_to_segments.md
# score_to_segments

- Converts a binary game score into four 8-bit active-low segment patterns: thousands, hundreds, tens, ones.
- Drives the four digit inputs of the multiplexed four-digit display driver, which sits directly downstream and only scans whatever patterns it is given.
- Uses a sequential shift-and-add-3 (double-dabble) BCD conversion, one bit per cycle, plus a start/busy/valid handshake toward the game-logic score counter.
- Holds the last converted patterns stable while a new conversion runs, so the display never shows partial results.

## Interface

Parameters:
- SCORE_W, default 14: score input width; legal range 4..14; also the number of shift iterations.

Ports:
- clk  in  1  system clock; one clock, all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion of `score`; sampled only in IDLE.
- score  in  SCORE_W  unsigned binary score.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  one-cycle pulse when new digit outputs are written.
- sat  out  1  high if the last conversion clamped its input; updated together with `valid`.
- thousands  out  8  segment pattern for the thousands digit.
- hundreds  out  8  segment pattern for the hundreds digit.
- tens  out  8  segment pattern for the tens digit.
- ones  out  8  segment pattern for the ones digit.

## Operation

- Segment bit order is {dp,g,f,e,d,c,b,a}, active low; dp is always 1 (off).
- Digit encoding:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
  - blank = FF; any non-BCD nibble also encodes as FF.
- FSM states: IDLE, SHIFT, ENCODE.
- IDLE, when `start`=1:
  - Load the shift register with `score`, clamped to 9999 if `score` > 9999.
  - Latch the clamp flag internally.
  - Clear the 16-bit BCD accumulator and the iteration counter.
  - Go to SHIFT.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd, bin} left by one bit.
  - After SCORE_W iterations, go to ENCODE.
- ENCODE:
  - Register all four encoded digits and `sat`, pulse `valid`, return to IDLE.
- `start` while not in IDLE is ignored; requests are not queued.
- `score` is sampled only in the IDLE cycle that accepts `start`; later changes have no effect on that conversion.
- Digit outputs and `sat` change only in the ENCODE cycle and otherwise hold their value.

## Timing

- `start` accepted at edge N (in IDLE).
- `busy`=1 from after edge N through edge N+SCORE_W+1; SHIFT occupies edges N+1..N+SCORE_W.
- ENCODE at edge N+SCORE_W+1:
  - digit outputs and `sat` update;
  - `valid`=1 for exactly that one cycle;
  - `busy` drops to 0 in the same cycle.
- Latency with SCORE_W=14: 15 cycles from `start` to `valid`.
- A new `start` is accepted one cycle after `valid` at the earliest (that cycle is IDLE).
- `start` held continuously gives back-to-back conversions every SCORE_W+2 cycles.
- Reset values: state IDLE, `busy`=0, `valid`=0, `sat`=0, all four digit outputs C0 ("0000").
- Reset mid-conversion: abort in the same edge and restore all reset values; no `valid` is issued for the aborted conversion.

## Configuration

- LEADING_ZERO_BLANK_EN defined:
  - In ENCODE, zero digits above the most significant nonzero digit are encoded FF; `ones` is never blanked.
  - Reset values become thousands/hundreds/tens = FF, ones = C0.
- Not defined: all four digits are always encoded, including leading zeros (0042 shows as C0 C0 99 A4).

## Test plan

- Reset, then score=1234, pulse `start` -> after 15 cycles, `valid` pulse, thousands=F9, hundreds=A4, tens=B0, ones=99, `sat`=0, `busy` low in the `valid` cycle.
- score=0 -> all four outputs C0; with LEADING_ZERO_BLANK_EN: FF FF FF C0.
- score=10000, then score=16383 -> each gives all outputs 90 and `sat`=1.
- Next conversion of 9999 -> outputs 90 and `sat` back to 0.
- score=42, change score to 7 during SHIFT, assert `start` again mid-conversion -> exactly one `valid`, showing C0 C0 99 A4 (FF FF 99 A4 with the macro); outputs hold their previous values until then.
- Assert `rst` at SHIFT iteration 6 -> next cycle `busy`=0, no `valid`, outputs equal the reset values; a subsequent conversion of 5 -> ones=92.
